// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled UART receiver with parity and framing status
// Samples each bit at its midpoint; timing advances only on rising edges of tick_i.
module uart_rx #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 tick_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 busy_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   logic                 rx_meta_q, rx_s_q, tick_q;
   logic [2:0]           state_q, state_d;
   logic [3:0]           scnt_q, scnt_d;
   logic [3:0]           bidx_q, bidx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 perr_q, perr_d;
   logic                 valid_q, valid_d;
   logic                 par_out_q, par_out_d;
   logic                 ferr_q, ferr_d;
   logic                 se, mid, par_bad;

   assign se      = tick_i & ~tick_q;
   assign mid     = se && (scnt_q == 4'd15);
   assign par_bad = (^shift_q) ^ rx_s_q;

   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q;
      bidx_d    = bidx_q;
      shift_d   = shift_q;
      perr_d    = perr_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      par_out_d = par_out_q;
      ferr_d    = ferr_q;
      case (state_q)
         S_IDLE: begin
            if (se && !rx_s_q) begin
               state_d = S_START;
               scnt_d  = 4'd0;
            end
         end
         S_START: begin
            // Only the mid-start-bit sample decides; earlier bounces are ignored.
            if (se) begin
               if (scnt_q == 4'd7) begin
                  scnt_d  = 4'd0;
                  bidx_d  = 4'd0;
                  perr_d  = 1'b0;
                  state_d = rx_s_q ? S_IDLE : S_DATA;
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
         end
         S_DATA: begin
            if (se) scnt_d = scnt_q + 4'd1;
            if (mid) begin
               shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
               bidx_d  = bidx_q + 4'd1;
               if (bidx_q == LAST_BIT) state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
         end
         S_PAR: begin
            if (se) scnt_d = scnt_q + 4'd1;
            if (mid) begin
               perr_d  = (PARITY == 2) ? ~par_bad : par_bad;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
            if (se) scnt_d = scnt_q + 4'd1;
            if (mid) begin
               data_d    = shift_q;
               ferr_d    = ~rx_s_q;
               par_out_d = (PARITY != 0) & perr_q;
               valid_d   = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         tick_q    <= 1'b0;
         state_q   <= S_IDLE;
         scnt_q    <= 4'd0;
         bidx_q    <= 4'd0;
         shift_q   <= '0;
         data_q    <= '0;
         perr_q    <= 1'b0;
         valid_q   <= 1'b0;
         par_out_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
         tick_q    <= tick_i;
         state_q   <= state_d;
         scnt_q    <= scnt_d;
         bidx_q    <= bidx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         perr_q    <= perr_d;
         valid_q   <= valid_d;
         par_out_q <= par_out_d;
         ferr_q    <= ferr_d;
      end
   end

   assign data_o       = data_q;
   assign valid_o      = valid_q;
   assign parity_err_o = par_out_q;
   assign frame_err_o  = ferr_q;
   assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (no parity, even and odd parity instances)
// Sender pushes expected words with their arrival slot; a monitor pops on each valid_o.
module tb_uart_rx;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      int         slot;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [2:0] rx_v = 3'b111;
   int         tick_hi = 1;
   int         phase = 0;
   int         slot = 0;
   event       slot_ev;
   int         checks = 0;
   int         errors = 0;
   exp_t       q0[$], q1[$], q2[$];

   logic [7:0] data0, data1, data2;
   logic       val0, val1, val2, pe0, pe1, pe2, fe0, fe1, fe2, busy0, busy1, busy2;

   uart_rx #(.DATA_BITS(8), .PARITY(0)) u0 (
      .clk_i(clk), .rst_i(rst), .tick_i(tick), .rx_i(rx_v[0]),
      .data_o(data0), .valid_o(val0), .parity_err_o(pe0), .frame_err_o(fe0), .busy_o(busy0));
   uart_rx #(.DATA_BITS(8), .PARITY(1)) u1 (
      .clk_i(clk), .rst_i(rst), .tick_i(tick), .rx_i(rx_v[1]),
      .data_o(data1), .valid_o(val1), .parity_err_o(pe1), .frame_err_o(fe1), .busy_o(busy1));
   uart_rx #(.DATA_BITS(8), .PARITY(2)) u2 (
      .clk_i(clk), .rst_i(rst), .tick_i(tick), .rx_i(rx_v[2]),
      .data_o(data2), .valid_o(val2), .parity_err_o(pe2), .frame_err_o(fe2), .busy_o(busy2));

   always #5 clk = ~clk;

   // Four clocks per slot; each slot starts with a tick rising edge.
   initial begin
      forever begin
         @(negedge clk);
         tick = (phase < tick_hi);
         if (phase == 0) begin
            slot = slot + 1;
            ->slot_ev;
         end
         phase = (phase == 3) ? 0 : phase + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected end of test");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int inst, input logic [7:0] d, input logic pe, input logic fe, input int s);
      exp_t e;
      e.data = d;
      e.perr = pe;
      e.ferr = fe;
      e.slot = s;
      case (inst)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic check_out(input int inst, input logic prev, input logic [7:0] d,
                            input logic pe, input logic fe);
      exp_t e;
      bit   have;
      have = 1'b0;
      chk("valid_width", {31'd0, prev}, 32'd0);
      case (inst)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      checks = checks + 1;
      if (!have) begin
         errors = errors + 1;
         $display("FAIL unexpected_valid: inst %0d got data %0h at slot %0d, expected no frame", inst, d, slot);
      end else begin
         chk("data", {24'd0, d}, {24'd0, e.data});
         chk("parity_err", {31'd0, pe}, {31'd0, e.perr});
         chk("frame_err", {31'd0, fe}, {31'd0, e.ferr});
         chk("valid_slot", slot, e.slot);
      end
   endtask

   initial begin
      logic p0, p1, p2;
      p0 = 1'b0; p1 = 1'b0; p2 = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (val0) check_out(0, p0, data0, pe0, fe0);
         if (val1) check_out(1, p1, data1, pe1, fe1);
         if (val2) check_out(2, p2, data2, pe2, fe2);
         p0 = val0; p1 = val1; p2 = val2;
      end
   end

   // Frame is LSB first; the word arrives 8 + 16*(bits after start) slots after the start sample.
   task automatic send_frame(input int inst, input logic [7:0] d, input bit has_par, input logic pbit,
                             input logic stop, input bit expect_v, input logic pe, input logic fe);
      logic [10:0] bits;
      int n;
      bits      = '0;
      bits[8:1] = d;
      n         = has_par ? 11 : 10;
      if (has_par) begin
         bits[9]  = pbit;
         bits[10] = stop;
      end else begin
         bits[9] = stop;
      end
      for (int i = 0; i < n; i++) begin
         if (i == 0) @(slot_ev);
         else repeat (16) @(slot_ev);
         if (i == 0 && expect_v) push(inst, d, pe, fe, slot + 1 + 8 + 16 * (n - 2) + 16);
         rx_v[inst] = bits[i];
      end
      repeat (15) @(slot_ev);
   endtask

   task automatic idle(input int n);
      @(slot_ev);
      rx_v = 3'b111;
      repeat (n - 1) @(slot_ev);
   endtask

   initial begin
      logic [7:0] partial;
      repeat (6) @(negedge clk);
      chk("reset_data", {24'd0, data0}, 32'd0);
      chk("reset_valid", {31'd0, val0}, 32'd0);
      chk("reset_perr", {31'd0, pe1}, 32'd0);
      chk("reset_ferr", {31'd0, fe0}, 32'd0);
      chk("reset_busy", {29'd0, busy2, busy1, busy0}, 32'd0);
      rst = 1'b0;
      idle(5);

      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(20);

      @(slot_ev);
      rx_v[0] = 1'b0;
      repeat (4) @(slot_ev);
      chk("false_start_busy_high", {31'd0, busy0}, 32'd1);
      rx_v[0] = 1'b1;
      repeat (8) @(slot_ev);
      chk("false_start_busy_low", {31'd0, busy0}, 32'd0);
      chk("false_start_data_held", {24'd0, data0}, 32'hA5);
      idle(10);
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(20);

      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(30);
      send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(20);

      send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(20);
      send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(20);
      send_frame(2, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(20);

      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(20);

      tick_hi = 3;
      idle(5);
      partial = 8'h6B;
      @(slot_ev);
      rx_v[0] = 1'b0;
      for (int j = 0; j < 3; j++) begin
         repeat (16) @(slot_ev);
         rx_v[0] = partial[j];
      end
      repeat (16) @(slot_ev);
      chk("busy_before_reset", {31'd0, busy0}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_reset_data", {24'd0, data0}, 32'd0);
      chk("mid_reset_valid", {31'd0, val0}, 32'd0);
      chk("mid_reset_perr", {31'd0, pe0}, 32'd0);
      chk("mid_reset_ferr", {31'd0, fe0}, 32'd0);
      chk("mid_reset_busy", {31'd0, busy0}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rx_v[0] = 1'b1;
      idle(20);
      send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(20);

      chk("pending_inst0", q0.size(), 32'd0);
      chk("pending_inst1", q1.size(), 32'd0);
      chk("pending_inst2", q2.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
